// File: rtl/lcd_pkg.sv
// Shared types and helpers for the character-LCD sequencer.
// Optional build macro LCD_4BIT_EN selects the nibble-wide bus variant,
// which adds the GAP state between the two nibbles of a word.
package lcd_pkg;

    // One ROM word: register select plus data byte
    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_word_t;

`ifdef LCD_4BIT_EN
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SETUP,
        PULSE,
        GAP,
        WAIT,
        FINISH
    } lcd_state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SETUP,
        PULSE,
        WAIT,
        FINISH
    } lcd_state_t;
`endif

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Clear/home are the slow commands; the controller decodes them on
    // data[7:2]==0, so every byte below 8'h04 (command register) counts.
    function automatic logic is_long_cmd(input lcd_word_t w);
        return !w.rs && ((w.data | (CMD_CLEAR | CMD_HOME)) == (CMD_CLEAR | CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by the SETUP, PULSE, GAP and WAIT phases.
// A load of N-1 on state entry keeps that state for exactly N cycles.
module lcd_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] value_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Reload has priority; otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/lcd_seq.sv
// HD44780-class command/text sequencer: plays `length` words from a
// combinational message ROM starting at `base_addr`, driving RS/E/DB with
// programmable setup, enable-pulse and busy-wait timing.
// Build macro LCD_4BIT_EN: send each word as two nibbles on lcd_db[7:4].
module lcd_seq #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ADDR_W       = $clog2(DEPTH),
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned EN_PULSE_CYC = 12,
    parameter int unsigned CMD_WAIT_CYC = 2000,
    parameter int unsigned CLR_WAIT_CYC = 76000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [8:0]        rom_data,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_e,
    output logic [7:0]        lcd_db
);

    import lcd_pkg::*;

    localparam int unsigned MAX_AB  = (SETUP_CYC > EN_PULSE_CYC) ? SETUP_CYC : EN_PULSE_CYC;
    localparam int unsigned MAX_CD  = (CMD_WAIT_CYC > CLR_WAIT_CYC) ? CMD_WAIT_CYC : CLR_WAIT_CYC;
    localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(EN_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_WAIT_CYC - 1);

    lcd_state_t        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    lcd_word_t         word_q, word_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              e_q, e_d;
`ifdef LCD_4BIT_EN
    logic              nib_q, nib_d;
`endif

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic [CNT_W-1:0]  tmr_value;
    logic              tmr_zero;

    lcd_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .value_o    (tmr_value),
        .zero_o     (tmr_zero)
    );

    // Next-state, datapath loads and timer reload on every timed-state entry
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        idx_d    = idx_q;
        word_d   = word_q;
`ifdef LCD_4BIT_EN
        nib_d    = nib_q;
`endif
        tmr_load = 1'b0;
        tmr_val  = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    len_d   = length;
                    idx_d   = '0;
                    state_d = (length == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                word_d   = lcd_word_t'(rom_data);
`ifdef LCD_4BIT_EN
                nib_d    = 1'b0;
`endif
                state_d  = SETUP;
                tmr_load = 1'b1;
                tmr_val  = SETUP_LD;
            end
            SETUP: begin
                if (tmr_zero) begin
                    state_d  = PULSE;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                end
            end
            PULSE: begin
                if (tmr_zero) begin
                    state_d  = WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = is_long_cmd(word_q) ? CLR_LD : CMD_LD;
`ifdef LCD_4BIT_EN
                    // High nibble just strobed: gap, then set up the low nibble
                    if (!nib_q) begin
                        state_d = GAP;
                        tmr_val = SETUP_LD;
                    end
`endif
                end
            end
`ifdef LCD_4BIT_EN
            GAP: begin
                if (tmr_zero) begin
                    nib_d    = 1'b1;
                    state_d  = SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LD;
                end
            end
`endif
            WAIT: begin
                if (tmr_zero) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ((idx_q + 1'b1) == len_q) ? FINISH : FETCH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE) && (state_d != FINISH);
        done_d = (state_d == FINISH);
        e_d    = (state_d == PULSE);
    end

    // State and datapath registers; outputs registered from next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            e_q     <= 1'b0;
`ifdef LCD_4BIT_EN
            nib_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            e_q     <= e_d;
`ifdef LCD_4BIT_EN
            nib_q   <= nib_d;
`endif
        end
    end

    // The enable pulse must never be loaded longer than programmed
    a_pulse_len: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == PULSE) |-> (tmr_value <= PULSE_LD));

    assign rom_addr = base_q + idx_q[ADDR_W-1:0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign lcd_e    = e_q;
    assign lcd_rs   = word_q.rs;
    assign lcd_rw   = 1'b0;
`ifdef LCD_4BIT_EN
    assign lcd_db   = {(nib_q ? word_q.data[3:0] : word_q.data[7:4]), 4'h0};
`else
    assign lcd_db   = word_q.data;
`endif

endmodule
